// File: rtl/fu_jump_sched_if.sv
// Signal bundle for fu_jump_sched: issue, jump-FU, flush, writeback and redirect.
// The stat_* counters exist only when FU_JUMP_SCHED_STATS_EN is defined.
interface fu_jump_sched_if;
    logic        iss_valid;
    logic        iss_ready;
    logic        iss_jal;
    logic        iss_jalr;
    logic [2:0]  iss_cmp_ctrl;
    logic [4:0]  iss_rd;

    logic        fu_en;
    logic        fu_jalr;
    logic [2:0]  fu_cmp_ctrl;
    logic        fu_cmp_res;
    logic [31:0] fu_pc_jump;
    logic [31:0] fu_pc_wb;

    logic        ext_flush;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        redirect;
    logic [31:0] redirect_pc;

`ifdef FU_JUMP_SCHED_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_taken;
`endif

    modport slave (
        input  iss_valid, iss_jal, iss_jalr, iss_cmp_ctrl, iss_rd,
        output iss_ready,
        output fu_en, fu_jalr, fu_cmp_ctrl,
        input  fu_cmp_res, fu_pc_jump, fu_pc_wb,
        input  ext_flush,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        output redirect, redirect_pc
`ifdef FU_JUMP_SCHED_STATS_EN
        , output stat_issued, stat_taken
`endif
    );

    modport master (
        output iss_valid, iss_jal, iss_jalr, iss_cmp_ctrl, iss_rd,
        input  iss_ready,
        input  fu_en, fu_jalr, fu_cmp_ctrl,
        output fu_cmp_res, fu_pc_jump, fu_pc_wb,
        output ext_flush,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        input  redirect, redirect_pc
`ifdef FU_JUMP_SCHED_STATS_EN
        , input stat_issued, stat_taken
`endif
    );
endinterface

// File: rtl/fu_jump_sched.sv
// Jump-op scheduler: queues jal/jalr/branch ops, runs them one at a time through the
// jump FU, then issues redirect and link writeback. Optional FU_JUMP_SCHED_STATS_EN adds counters.
module fu_jump_sched #(
    parameter int QDEPTH  = 2,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    fu_jump_sched_if.slave bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(LATENCY);

    typedef struct packed {
        logic       jal;
        logic       jalr;
        logic [2:0] cmp_ctrl;
        logic [4:0] rd;
    } op_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    op_t              mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    op_t              op;

    op_t  in_op;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic capture;
    logic taken;
    logic clear_q;

    assign in_op  = {bus.iss_jal, bus.iss_jalr, bus.iss_cmp_ctrl, bus.iss_rd};
    assign full   = (count == (PTR_W+1)'(QDEPTH));
    assign empty  = (count == '0);
    assign push   = bus.iss_valid && !full;
    assign pop    = (state == IDLE) && !empty && !bus.ext_flush;

    // Result is sampled on the last WAIT cycle; a taken op makes every queued op wrong-path.
    assign capture = (state == WAIT) && (cnt == CNT_W'(1));
    assign taken   = op.jal || op.jalr || bus.fu_cmp_res;
    assign clear_q = bus.ext_flush || (capture && taken);

    assign bus.iss_ready   = !full;
    assign bus.fu_jalr     = op.jalr;
    assign bus.fu_cmp_ctrl = op.cmp_ctrl;
    assign bus.wb_rd       = op.rd;

    // NOTE: queue storage has no reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push && !clear_q) begin
            mem[wr_ptr] <= in_op;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_q) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            op              <= '0;
            bus.fu_en       <= 1'b0;
            bus.wb_valid    <= 1'b0;
            bus.wb_data     <= '0;
            bus.redirect    <= 1'b0;
            bus.redirect_pc <= '0;
        end else begin
            bus.fu_en    <= 1'b0;
            bus.redirect <= 1'b0;
            if (bus.ext_flush) begin
                state        <= IDLE;
                cnt          <= '0;
                bus.wb_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!empty) begin
                            op        <= mem[rd_ptr];
                            bus.fu_en <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= WAIT;
                    end
                    WAIT: begin
                        cnt <= cnt - CNT_W'(1);
                        if (capture) begin
                            bus.redirect_pc <= bus.fu_pc_jump;
                            bus.wb_data     <= bus.fu_pc_wb;
                            bus.redirect    <= taken;
                            if ((op.jal || op.jalr) && (op.rd != 5'd0)) begin
                                bus.wb_valid <= 1'b1;
                                state        <= RESP;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    RESP: begin
                        if (bus.wb_ready) begin
                            bus.wb_valid <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FU_JUMP_SCHED_STATS_EN
    // Lifetime counters: only reset clears them, a pipeline flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stat_issued <= '0;
            bus.stat_taken  <= '0;
        end else begin
            if (bus.fu_en) begin
                bus.stat_issued <= bus.stat_issued + 32'd1;
            end
            if (bus.redirect) begin
                bus.stat_taken <= bus.stat_taken + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
